// File: rtl/pc_mux_pkg.sv
// pc_mux_pkg: shared constants and types for the RV32 next-PC path.
//   XLEN          - datapath / PC width
//   RESET_VECTOR  - PC value loaded on reset
//   pc_src_e      - next-PC select encodings
package pc_mux_pkg;

   localparam int          XLEN         = 32;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_SRC_PLUS4  = 2'd0,
      PC_SRC_TARGET = 2'd1,
      PC_SRC_ALU    = 2'd2,
      PC_SRC_HOLD   = 2'd3
   } pc_src_e;

endpackage

// File: rtl/pc_mux_reg.sv
// pc_reg: reset-vector register with load enable.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, loads RESET_VALUE
//   en   - load enable; when low the register holds
//   d    - next value
//   q    - registered value
module pc_reg #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: state is written with non-blocking assignments so every flop
   // samples its inputs before any of them change on this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VALUE;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pc_mux.sv
// pc_mux: next-PC selector and architectural PC register.
//   clk, rst       - clock and synchronous active-high reset
//   pc_src         - select: 0 plus4, 1 target, 2 alu (JALR), 3 hold
//   pc_plus4       - current PC + 4
//   pc_target      - branch/JAL target
//   pc_alu         - JALR target (rs1 + imm)
//   pc_prev        - current PC, used for stalls
//   pc_next        - selected next PC (combinational)
//   pc_misaligned  - pc_next not word aligned (combinational)
//   pc             - registered architectural PC
//   pc_trap        - last update was refused because of misalignment
module pc_mux #(
   parameter int              XLEN         = pc_mux_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = pc_mux_pkg::RESET_VECTOR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [XLEN-1:0] pc_target,
   input  logic [XLEN-1:0] pc_alu,
   input  logic [XLEN-1:0] pc_prev,
   output logic [XLEN-1:0] pc_next,
   output logic            pc_misaligned,
   output logic [XLEN-1:0] pc,
   output logic            pc_trap
);

   import pc_mux_pkg::*;

   // JALR target with bit 0 cleared before the alignment check.
   logic [XLEN-1:0] jalr_target;
   assign jalr_target = pc_alu & ~XLEN'(1);

   // NOTE: pc_next gets a value on every path (the default arm covers any
   // encoding), so no latch is inferred.
   always_comb begin
      case (pc_src_e'(pc_src))
         PC_SRC_PLUS4:  pc_next = pc_plus4;
         PC_SRC_TARGET: pc_next = pc_target;
         PC_SRC_ALU:    pc_next = jalr_target;
         default:       pc_next = pc_prev;
      endcase
   end

   assign pc_misaligned = |pc_next[1:0];

   // A misaligned candidate is refused: the PC holds and the trap flag rises.
   pc_reg #(
      .WIDTH       (XLEN),
      .RESET_VALUE (RESET_VECTOR)
   ) u_pc_reg (
      .clk (clk),
      .rst (rst),
      .en  (!pc_misaligned),
      .d   (pc_next),
      .q   (pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_trap <= 1'b0;
      end else begin
         pc_trap <= pc_misaligned;
      end
   end

endmodule

// File: tb/tb_pc_mux.sv
// tb_pc_mux: self-checking bench for pc_mux. Directed steps followed by
// random cycles, all compared against a behavioural model of the PC.
module tb_pc_mux;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pc_src;
   logic [31:0] pc_plus4, pc_target, pc_alu, pc_prev;
   logic [31:0] pc_next, pc;
   logic        pc_misaligned, pc_trap;

   int checks = 0;
   int errors = 0;

   // model state
   logic [31:0] m_pc;
   logic        m_trap;

   pc_mux #(.XLEN(32), .RESET_VECTOR(RV)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_src        (pc_src),
      .pc_plus4      (pc_plus4),
      .pc_target     (pc_target),
      .pc_alu        (pc_alu),
      .pc_prev       (pc_prev),
      .pc_next       (pc_next),
      .pc_misaligned (pc_misaligned),
      .pc            (pc),
      .pc_trap       (pc_trap)
   );

   always #5 clk = ~clk;

   // Reference: pick the candidate by index; the JALR candidate is rounded
   // down to an even address.
   function automatic logic [31:0] ref_next(input logic [1:0] s, input logic [31:0] p4,
                                            input logic [31:0] tg, input logic [31:0] al,
                                            input logic [31:0] pv);
      logic [31:0] cand [4];
      cand[0] = p4;
      cand[1] = tg;
      cand[2] = al - (al % 2);
      cand[3] = pv;
      return cand[s];
   endfunction

   function automatic logic ref_mis(input logic [31:0] a);
      return (a % 4) != 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] s, input logic [31:0] p4,
                        input logic [31:0] tg, input logic [31:0] al, input logic [31:0] pv);
      rst = r; pc_src = s; pc_plus4 = p4; pc_target = tg; pc_alu = al; pc_prev = pv;
   endtask

   // Check the combinational outputs, clock once, update the model and check
   // the registered outputs. Called 1 ns after a rising edge.
   task automatic cycle(input string tag);
      logic [31:0] en;
      logic        em;
      #1;
      en = ref_next(pc_src, pc_plus4, pc_target, pc_alu, pc_prev);
      em = ref_mis(en);
      chk({tag, ".pc_next"}, pc_next, en);
      chk({tag, ".mis"}, {31'd0, pc_misaligned}, {31'd0, em});
      @(posedge clk);
      #1;
      if (rst) begin
         m_pc = RV; m_trap = 1'b0;
      end else if (!em) begin
         m_pc = en; m_trap = 1'b0;
      end else begin
         m_trap = 1'b1;
      end
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".trap"}, {31'd0, pc_trap}, {31'd0, m_trap});
   endtask

   initial begin
      logic [31:0] exp_tab [4];
      logic [31:0] r;
      m_pc = RV; m_trap = 1'b0;

      // combinational mux sweep, reset held so state is defined
      exp_tab[0] = 32'h1111_1111; exp_tab[1] = 32'h2222_2222;
      exp_tab[2] = 32'h3333_3332; exp_tab[3] = 32'hFFFF_FFFF;
      drive(1'b1, 2'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hFFFF_FFFF);
      for (int s = 0; s < 4; s++) begin
         pc_src = 2'(s);
         #2;
         chk($sformatf("mux%0d", s), pc_next, exp_tab[s]);
         chk($sformatf("mux%0d.mis", s), {31'd0, pc_misaligned}, 32'd1);
      end

      // reset for two edges, with a misaligned select present
      @(posedge clk); #1;
      drive(1'b1, 2'd1, 32'h4, 32'h0000_0102, 32'h0, 32'h0);
      cycle("rst1");
      chk("rst1.pc_const", pc, 32'h0);
      drive(1'b1, 2'd2, 32'h4, 32'h0, 32'h0000_0203, 32'h0);
      cycle("rst2");

      // sequential fetch 4, 8, C
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 2'd0, m_pc + 32'd4, 32'h0000_0001, 32'h0, m_pc);
         cycle($sformatf("seq%0d", i));
         chk($sformatf("seq%0d.const", i), pc, 32'(4 * (i + 1)));
      end

      // JALR clears bit 0
      drive(1'b0, 2'd2, m_pc + 32'd4, 32'h0, 32'h0000_0101, m_pc);
      cycle("jalr");
      chk("jalr.const", pc, 32'h100);

      // misaligned branch refused, then recovery
      drive(1'b0, 2'd1, 32'h104, 32'h0000_0102, 32'h0, m_pc);
      cycle("misbr");
      chk("misbr.const", pc, 32'h100);
      drive(1'b0, 2'd1, 32'h104, 32'h0000_0106, 32'h0, m_pc);
      cycle("misbr2");
      drive(1'b0, 2'd0, 32'h104, 32'h0000_0106, 32'h0, m_pc);
      cycle("recover");
      chk("recover.const", pc, 32'h104);

      // clean stall
      drive(1'b0, 2'd3, 32'h108, 32'h0, 32'h0, m_pc);
      cycle("stall");

      // reset overrides a misaligned select
      drive(1'b1, 2'd1, 32'h108, 32'h0000_0203, 32'h0, m_pc);
      cycle("rstmis");
      chk("rstmis.const", pc, RV);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         r = $urandom;
         drive(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
               (r[0] ? m_pc + 32'd4 : $urandom),
               ($urandom & (r[1] ? 32'hFFFF_FFFC : 32'hFFFF_FFFF)),
               ($urandom & (r[2] ? 32'hFFFF_FFFD : 32'hFFFF_FFFF)),
               (r[3] ? m_pc : $urandom));
         cycle($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_mux.md
# pc_mux

Next-program-counter selector and PC register for the single-cycle RV32 core. It picks the next PC from four candidates (sequential, branch/JAL target, JALR ALU result, hold) under control of `pc_src`. It flags misaligned fetch addresses and registers the result as the architectural PC on each clock. It sits between the branch/ALU datapath and the instruction-memory address port.

## Interface
Parameters:
- `XLEN`, 32, datapath/PC width.
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  input  1  core clock, all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `pc_src`  input  2  next-PC select: 0 = `pc_plus4`, 1 = `pc_target`, 2 = `pc_alu`, 3 = `pc_prev`.
- `pc_plus4`  input  XLEN  current PC + 4.
- `pc_target`  input  XLEN  PC-relative branch/JAL target.
- `pc_alu`  input  XLEN  JALR target from ALU (rs1 + imm).
- `pc_prev`  input  XLEN  current PC, used for stall/hold.
- `pc_next`  output  XLEN  selected next PC (combinational).
- `pc_misaligned`  output  1  `pc_next[1:0] != 0` (combinational).
- `pc`  output  XLEN  registered architectural PC.
- `pc_trap`  output  1  registered: last update was refused due to misalignment.

## Operation
- Mux, fully combinational, no priority:
  - 0: `pc_next = pc_plus4`
  - 1: `pc_next = pc_target`
  - 2: `pc_next = {pc_alu[XLEN-1:1], 1'b0}` (JALR LSB clear, per RV32I)
  - 3: `pc_next = pc_prev`
- `pc_src` is a full 2-bit decode. No X-propagation special case. Default branch equals encoding 3 (hold).
- `pc_misaligned = |pc_next[1:0]`. It is evaluated after the JALR bit-0 clear.
- Register, on each rising `clk`:
  - `rst`=1: `pc <= RESET_VECTOR`, `pc_trap <= 0`.
  - Else if `pc_misaligned`=0: `pc <= pc_next`, `pc_trap <= 0`.
  - Else: `pc` keeps its value, `pc_trap <= 1`.
- No arithmetic inside the block. Candidate values are consumed as-is. No overflow handling is needed because `pc_plus4` wrap is produced upstream.

## Timing
- `pc_next` and `pc_misaligned`: zero-cycle combinational from any input.
- `pc` and `pc_trap`: one-cycle latency from `pc_next`.
- Reset values: `pc = RESET_VECTOR`, `pc_trap = 0`. Combinational outputs follow inputs during reset.
- Reset asserted mid-operation overrides any select, including a misaligned candidate, on that edge.
- Reset deasserts: the first non-reset edge loads `pc_next`.
- `pc_src` = 3 with `pc_prev` = `pc` is a clean stall. `pc` is unchanged and `pc_trap` is 0.
- Misaligned selects on consecutive cycles keep `pc` frozen and `pc_trap` high until an aligned select arrives.

## Structure
- Shared core package holds:
  - `XLEN`
  - `RESET_VECTOR`
  - `pc_src` encodings: `PC_SRC_PLUS4=2'd0`, `PC_SRC_TARGET=2'd1`, `PC_SRC_ALU=2'd2`, `PC_SRC_HOLD=2'd3`
- One natural sub-module: `pc_reg` (reset-vector register with load-enable), instantiated here with enable = `!pc_misaligned`.
- Mux and alignment check stay in the top block.

## Test plan
- Inputs `pc_plus4`=0x11111111, `pc_target`=0x22222222, `pc_alu`=0x33333333, `pc_prev`=0xFFFFFFFF; step `pc_src` 0,1,2,3 every 2 ns. Required `pc_next` = 0x11111111, 0x22222222, 0x33333332, 0xFFFFFFFF, with `pc_misaligned` = 1, 1, 1, 1.
- Hold `rst`=1 for 2 clocks with `RESET_VECTOR`=0x0000_0000. Required: `pc`=0x00000000 and `pc_trap`=0 after the first edge, regardless of `pc_src`.
- Release reset with `pc_src`=0 and `pc_plus4` = `pc`+4 each cycle. Required: `pc` goes 0x4, 0x8, 0xC on successive edges and `pc_trap` stays 0.
- Drive `pc_src`=2, `pc_alu`=0x00000101. Required: `pc_next`=0x00000100, `pc_misaligned`=0, and `pc` loads 0x100.
- Drive `pc_src`=1, `pc_target`=0x00000102. Required: `pc_misaligned`=1, `pc` unchanged at 0x100, and `pc_trap`=1 after the edge. Then drive `pc_src`=0 with `pc_plus4`=0x104. Required: `pc`=0x104 and `pc_trap`=0.
- Set `pc_src`=1 with a misaligned target and assert `rst` in the same cycle. Required: `pc`=`RESET_VECTOR` and `pc_trap`=0.
